ula_wb_stage: RTL
=================

Name: ula_wb_stage

Overview:
- Writeback/flags stage directly downstream of the ALU (ula).
- Accepts one ALU result per handshake: opcode, destination register, result, per-instruction rflags.
- Buffers results in a 2-entry skid FIFO and drives the register-file write port in order.
- Maintains the architectural flags register: compare flags replaced, overflow/div-by-zero sticky, and raises a one-cycle exception pulse.

Parameters:
- DATA_WIDTH, 16, result/write-data width
- OPCODE_WIDTH, 4, opcode width, same encoding as ALU
- RFLAGS_WIDTH, 5, flags width
- REG_ADDR_WIDTH, 4, register-file address width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_opcode  in  OPCODE_WIDTH  instruction opcode
- in_rd  in  REG_ADDR_WIDTH  destination register
- in_result  in  DATA_WIDTH  ALU out
- in_rflags  in  RFLAGS_WIDTH  ALU rflags (bit0 div0, bit1 lt, bit2 eq, bit3 gt, bit4 ovf)
- wb_en  out  1  register-file write request
- wb_ready  in  1  register file accepts write this cycle
- wb_addr  out  REG_ADDR_WIDTH  write address
- wb_data  out  DATA_WIDTH  write data
- flag_clr  in  1  clear sticky bits 0 and 4
- rflags_q  out  RFLAGS_WIDTH  architectural flags register
- exc  out  1  one-cycle pulse: div0 or overflow committed

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied.
  - wb_en=0, wb_addr=0, wb_data=0, rflags_q=0, exc=0, in_ready=1.
  - Reset mid-operation discards every buffered and pending entry; nothing is written after release.
- Input:
  - Transfer on in_valid && in_ready at a rising edge.
  - in_ready = FIFO count < 2, derived from registered count only (no combinational path from wb_ready).
- Commit:
  - FIFO head commits at an edge when the FIFO is non-empty and the output slot is free, i.e. wb_en==0, or wb_en && wb_ready at that edge.
  - Commit pops the head and updates rflags_q in program order.
- Output slot:
  - Per committed instruction:
    - CMP, or DIV with in_rflags[0]=1: wb_en=0.
    - Otherwise: wb_en=1, wb_addr=rd, wb_data=result.
  - wb_en/addr/data held stable until wb_ready. A write completes on wb_en && wb_ready.
- Latency: accepted at edge N → earliest wb_en high after edge N+1.
- Throughput: 1/cycle while wb_ready=1. Capacity 3 in flight (2 FIFO + 1 output).
- Simultaneous accept and commit in one cycle is legal; count unchanged.
- Flag update at commit:
  - CMP: rflags_q[3:1] ← in_rflags[3:1]; bits 0 and 4 untouched.
  - ADD/SUB/MUL: rflags_q[4] |= in_rflags[4].
  - DIV: rflags_q[0] |= in_rflags[0].
  - AND/OR/NOT/others: flags unchanged.
  - CMP overflow is not recorded.
- flag_clr:
  - Clears bits 0 and 4 at the edge.
  - If a commit sets either bit at the same edge, set wins.
- exc: high for exactly the cycle after an edge committing a DIV with div0, or an ADD/SUB/MUL with ovf. Registered.
- No backpressure bypass: when wb_ready is low with FIFO full, in_ready=0 and upstream must hold.

Decomposition:
- params_proc.v (shared, included):
  - Existing opcode constants and widths.
  - New flag index constants RF_DIV0=0, RF_LT=1, RF_EQ=2, RF_GT=3, RF_OVF=4.
- Sub-module ula_wb_skid:
  - 2-entry FIFO, width OPCODE_WIDTH+REG_ADDR_WIDTH+DATA_WIDTH+RFLAGS_WIDTH.
  - push/pop/full/empty/head, async active-low reset.
- Top level holds the output slot, flag register and exc logic.

Test Plan:
- ADD, rd=3, result=0x0005, rflags=0, wb_ready=1 accepted at edge 1 → wb_en=1, wb_addr=3, wb_data=0x0005 after edge 2; rflags_q=0; exc=0.
- CMP with in_rflags=5'b01000 then CMP with 5'b00100 → rflags_q=5'b01000 then 5'b00100; wb_en never asserted.
- DIV, in_rflags=5'b00001, rd=2 → no write to r2; rflags_q[0]=1; exc high one cycle; later AND commit leaves bit0=1 until flag_clr.
- wb_ready=0 for 5 cycles, 4 back-to-back ADDs (rd 1..4) offered → in_ready low after 3 accepted; wb_ready=1 → writes r1,r2,r3,r4 in order on consecutive cycles, data intact.
- rflags_q[4]=1 and flag_clr=1 at the same edge an overflowing MUL (0x4000*0x0004) commits → rflags_q[4] stays 1; flag_clr next cycle alone → 0.
- 2 entries buffered and wb_en pending, rst_n pulsed low between edges → outputs zero immediately; after release no wb_en; in_ready=1.

Source files
------------

// File: rtl/ula_wb_stage_pkg.sv
// rtl/ula_wb_stage_pkg.sv - shared widths, opcodes and flag indices for the ALU writeback stage
package ula_wb_stage_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_OPCODE_WIDTH   = 4;
  localparam int DEF_RFLAGS_WIDTH   = 5;
  localparam int DEF_REG_ADDR_WIDTH = 4;

  // Opcode encoding shared with the ALU
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;

  // Flag bit positions inside rflags
  localparam int RF_DIV0 = 0;
  localparam int RF_LT   = 1;
  localparam int RF_EQ   = 2;
  localparam int RF_GT   = 3;
  localparam int RF_OVF  = 4;

  // Arithmetic ops that can report overflow
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  // Compares and faulting divides produce no register write
  function automatic logic writes_rf(input logic [3:0] op, input logic div0);
    return !((op == OP_CMP) || ((op == OP_DIV) && div0));
  endfunction

endpackage

// File: rtl/ula_wb_skid.sv
// rtl/ula_wb_skid.sv - two-entry skid FIFO holding ALU results awaiting commit
module ula_wb_skid #(
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state: guarded push/pop, pointers toggle, count tracks occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ula_wb_stage.sv
// rtl/ula_wb_stage.sv - ALU writeback stage: skid buffer, register-file write slot, flags and exception
module ula_wb_stage
  import ula_wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OPCODE_WIDTH   = DEF_OPCODE_WIDTH,
  parameter int RFLAGS_WIDTH   = DEF_RFLAGS_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPCODE_WIDTH-1:0]   in_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic [RFLAGS_WIDTH-1:0]   in_rflags,
  output logic                      wb_en,
  input  logic                      wb_ready,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      flag_clr,
  output logic [RFLAGS_WIDTH-1:0]   rflags_q,
  output logic                      exc
);

  localparam int EW = OPCODE_WIDTH + REG_ADDR_WIDTH + DATA_WIDTH + RFLAGS_WIDTH;

  logic                      fifo_full, fifo_empty, push, commit;
  logic [EW-1:0]             head;
  logic [OPCODE_WIDTH-1:0]   h_op;
  logic [REG_ADDR_WIDTH-1:0] h_rd;
  logic [DATA_WIDTH-1:0]     h_res;
  logic [RFLAGS_WIDTH-1:0]   h_rf;

  logic                      wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [RFLAGS_WIDTH-1:0]   rflags_d;
  logic                      exc_q, exc_d;

  // Ready depends only on the registered FIFO count, never on wb_ready
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign commit   = !fifo_empty && (!wb_en_q || wb_ready);
  assign {h_op, h_rd, h_res, h_rf} = head;

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign exc     = exc_q;

  ula_wb_skid #(.WIDTH(EW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_opcode, in_rd, in_result, in_rflags}),
    .pop       (commit),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Commit logic: load the write slot, update flags in program order, raise exception
  always_comb begin
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    rflags_d  = rflags_q;
    exc_d     = 1'b0;
    // Clear first so that a sticky bit set by the same commit survives
    if (flag_clr) begin
      rflags_d[RF_DIV0] = 1'b0;
      rflags_d[RF_OVF]  = 1'b0;
    end
    if (commit) begin
      if (writes_rf(h_op, h_rf[RF_DIV0])) begin
        wb_en_d   = 1'b1;
        wb_addr_d = h_rd;
        wb_data_d = h_res;
      end else begin
        wb_en_d = 1'b0;
      end
      if (h_op == OP_CMP) begin
        rflags_d[RF_GT:RF_LT] = h_rf[RF_GT:RF_LT];
      end else if (is_arith(h_op)) begin
        rflags_d[RF_OVF] = rflags_d[RF_OVF] | h_rf[RF_OVF];
        exc_d            = h_rf[RF_OVF];
      end else if (h_op == OP_DIV) begin
        rflags_d[RF_DIV0] = rflags_d[RF_DIV0] | h_rf[RF_DIV0];
        exc_d             = h_rf[RF_DIV0];
      end
    end else if (wb_en_q && wb_ready) begin
      wb_en_d = 1'b0;
    end
  end

  // Output slot, flag register and exception pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rflags_q  <= '0;
      exc_q     <= 1'b0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      rflags_q  <= rflags_d;
      exc_q     <= exc_d;
    end
  end

endmodule
